// File: rtl/mem_pkg.sv
// Shared constants and types for the byte-laned data memory controller.
package mem_pkg;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  localparam int ERR_MISALIGN = 0;
  localparam int ERR_RANGE    = 1;
  localparam int ERR_SIZE     = 2;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  // Little-endian lane selection for a store of the given size at byte offset off.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] m;
    case (size)
      SIZE_B:  m = 4'b0001 << off;
      SIZE_H:  m = off[1] ? 4'b1100 : 4'b0011;
      SIZE_W:  m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/byte_lane_ram.sv
// One 8-bit memory lane: synchronous write enable, registered read.
module byte_lane_ram #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [7:0]        i_wr_data,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [7:0]        o_rd_data
);

  logic [7:0] r_mem [2**ADDR_W];
  logic [7:0] r_rd_data;

  // No reset: contents survive a controller reset.
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_wr_addr] <= i_wr_data;
    r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/data_mem_ctrl.sv
// Byte-laned data memory with valid/ready requests, checked accesses,
// optional zero-fill after reset and a 1- or 2-cycle response pipeline.
module data_mem_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W       = 10,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int unsigned READ_LATENCY = 1,
  parameter bit          INIT_ZERO    = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [1:0]  i_req_size,
  input  logic        i_req_signed,
  input  logic [31:0] i_address,
  input  logic [31:0] i_wr_data,
  output logic        o_rsp_valid,
  output logic [31:0] o_rsp_data,
  output logic [2:0]  o_rsp_err,
  output logic        o_init_done
);

  localparam int unsigned     DEPTH    = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  state_t            r_state;
  state_t            w_state_next;
  logic [ADDR_W-1:0] r_init_idx;
  logic              r_ready;
  logic              r_init_done;
  logic              w_init_we;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_state <= INIT_ZERO ? ST_INIT : ST_RUN;
    else            r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_init_we    = 1'b0;
    case (r_state)
      ST_INIT: begin
        w_init_we = 1'b1;
        if (r_init_idx == LAST_IDX) w_state_next = ST_RUN;
      end
      ST_RUN:  w_state_next = ST_RUN;
      default: w_state_next = r_state;
    endcase
  end

  // Ready is registered so it stays low during reset and rises on the edge after the last fill.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_init_idx  <= '0;
      r_ready     <= 1'b0;
      r_init_done <= 1'b0;
    end else begin
      if (w_init_we) r_init_idx <= r_init_idx + 1'b1;
      r_ready     <= (w_state_next == ST_RUN);
      r_init_done <= (w_state_next == ST_RUN);
    end
  end

  logic              w_accept;
  logic [1:0]        w_off;
  logic [2:0]        w_err;
  logic [ADDR_W-1:0] w_word_idx;
  logic [3:0]        w_be;
  logic [31:0]       w_wr_word;
  logic [31:0]       w_rd_word;

  assign w_accept   = i_req_valid && r_ready;
  assign w_off      = i_address[1:0];
  assign w_word_idx = i_address[ADDR_W+1:2];

  always_comb begin
    w_err               = 3'b000;
    w_err[ERR_MISALIGN] = ((i_req_size == SIZE_H) && w_off[0]) ||
                          ((i_req_size == SIZE_W) && (w_off != 2'b00));
    w_err[ERR_RANGE]    = (i_address[31:ADDR_W+2] != BASE_ADDR[31:ADDR_W+2]);
    w_err[ERR_SIZE]     = (i_req_size == 2'd3);
  end

  assign w_be = lane_mask(i_req_size, w_off) & {4{w_accept && i_req_we && (w_err == 3'b000)}};

  // Replicate sub-word store data so each lane sees its byte regardless of offset.
  always_comb begin
    case (i_req_size)
      SIZE_B:  w_wr_word = {4{i_wr_data[7:0]}};
      SIZE_H:  w_wr_word = {2{i_wr_data[15:0]}};
      default: w_wr_word = i_wr_data;
    endcase
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      byte_lane_ram #(.ADDR_W(ADDR_W)) u_lane (
        .i_clk     (i_clk),
        .i_we      (w_init_we | w_be[gi]),
        .i_wr_addr (w_init_we ? r_init_idx : w_word_idx),
        .i_wr_data (w_init_we ? 8'h00 : w_wr_word[8*gi +: 8]),
        .i_rd_addr (w_word_idx),
        .o_rd_data (w_rd_word[8*gi +: 8])
      );
    end
  endgenerate

  logic       r_s1_valid;
  logic       r_s1_load;
  logic [1:0] r_s1_size;
  logic       r_s1_signed;
  logic [1:0] r_s1_off;
  logic [2:0] r_s1_err;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_load   <= 1'b0;
      r_s1_size   <= 2'b00;
      r_s1_signed <= 1'b0;
      r_s1_off    <= 2'b00;
      r_s1_err    <= 3'b000;
    end else begin
      r_s1_valid  <= w_accept;
      r_s1_load   <= w_accept && !i_req_we && (w_err == 3'b000);
      r_s1_size   <= i_req_size;
      r_s1_signed <= i_req_signed;
      r_s1_off    <= w_off;
      r_s1_err    <= w_accept ? w_err : 3'b000;
    end
  end

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ext;
  logic [31:0] w_rsp_data;

  assign w_byte = 8'(w_rd_word >> {r_s1_off, 3'b000});
  assign w_half = r_s1_off[1] ? w_rd_word[31:16] : w_rd_word[15:0];

  always_comb begin
    case (r_s1_size)
      SIZE_B:  w_ext = {{24{r_s1_signed & w_byte[7]}}, w_byte};
      SIZE_H:  w_ext = {{16{r_s1_signed & w_half[15]}}, w_half};
      default: w_ext = w_rd_word;
    endcase
  end

  // Stores, errors and idle cycles present zero data.
  assign w_rsp_data = r_s1_load ? w_ext : 32'h0;

  generate
    if (READ_LATENCY == 1) begin : g_lat1
      assign o_rsp_valid = r_s1_valid;
      assign o_rsp_data  = w_rsp_data;
      assign o_rsp_err   = r_s1_err;
    end else if (READ_LATENCY == 2) begin : g_lat2
      logic        r_s2_valid;
      logic [31:0] r_s2_data;
      logic [2:0]  r_s2_err;

      always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
          r_s2_valid <= 1'b0;
          r_s2_data  <= 32'h0;
          r_s2_err   <= 3'b000;
        end else begin
          r_s2_valid <= r_s1_valid;
          r_s2_data  <= w_rsp_data;
          r_s2_err   <= r_s1_err;
        end
      end

      assign o_rsp_valid = r_s2_valid;
      assign o_rsp_data  = r_s2_data;
      assign o_rsp_err   = r_s2_err;
    end else begin : g_bad_latency
      $error("data_mem_ctrl: READ_LATENCY must be 1 or 2");
    end
  endgenerate

  generate
    if (ADDR_W < 1 || ADDR_W > 29) begin : g_bad_addr_w
      $error("data_mem_ctrl: ADDR_W must be in 1..29");
    end
  endgenerate

  assign o_req_ready = r_ready;
  assign o_init_done = r_init_done;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench: two controllers (latency 1 and 2) share one request stream
// and are compared against a byte-array reference model with timed expectations.
module tb_data_mem_ctrl;
  import mem_pkg::*;

  localparam int          AW     = 4;
  localparam int          NBYTES = 4 * (2**AW);
  localparam logic [31:0] BASE   = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wd = 32'h0;

  logic        rdy1, v1, done1, rdy2, v2, done2;
  logic [31:0] d1, d2;
  logic [2:0]  e1, e2;

  always #5 clk = ~clk;

  data_mem_ctrl #(.ADDR_W(AW), .BASE_ADDR(BASE), .READ_LATENCY(1), .INIT_ZERO(1'b1)) u_dut1 (
    .i_clk(clk), .i_reset_n(rst_n), .i_req_valid(req_valid), .o_req_ready(rdy1),
    .i_req_we(req_we), .i_req_size(req_size), .i_req_signed(req_signed),
    .i_address(req_addr), .i_wr_data(req_wd), .o_rsp_valid(v1), .o_rsp_data(d1),
    .o_rsp_err(e1), .o_init_done(done1));

  data_mem_ctrl #(.ADDR_W(AW), .BASE_ADDR(BASE), .READ_LATENCY(2), .INIT_ZERO(1'b1)) u_dut2 (
    .i_clk(clk), .i_reset_n(rst_n), .i_req_valid(req_valid), .o_req_ready(rdy2),
    .i_req_we(req_we), .i_req_size(req_size), .i_req_signed(req_signed),
    .i_address(req_addr), .i_wr_data(req_wd), .o_rsp_valid(v2), .o_rsp_data(d2),
    .o_rsp_err(e2), .o_init_done(done2));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  bit mon_en = 1'b0;

  typedef struct {
    int          due;
    logic [31:0] data;
    logic [2:0]  err;
  } rsp_t;

  rsp_t q1[$];
  rsp_t q2[$];
  logic [7:0] mdl [NBYTES];

  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] xd;
    logic [2:0]  xe;
  } vec_t;

  vec_t vecs[20];

  // Reference: a flat byte array, error rules applied directly to the byte address.
  function automatic void model_req(input logic we, input logic [1:0] sz, input logic sgn,
                                    input logic [31:0] a, input logic [31:0] wd,
                                    output logic [31:0] d, output logic [2:0] e);
    int n;
    int off;
    logic [31:0] mask;
    d = 32'h0;
    e = 3'b000;
    n = 1;
    if (sz == 2'd3) e[2] = 1'b1;
    else begin
      n = 1 << sz;
      if ((a % n) != 0) e[0] = 1'b1;
    end
    if ({1'b0, a} < {1'b0, BASE} || {1'b0, a} >= ({1'b0, BASE} + 33'(NBYTES))) e[1] = 1'b1;
    if (e == 3'b000) begin
      off = int'(a - BASE);
      if (we) begin
        for (int i = 0; i < n; i++) mdl[off + i] = wd[8*i +: 8];
      end else begin
        for (int i = 0; i < n; i++) d = d | (32'(mdl[off + i]) << (8*i));
        if (n < 4 && sgn && d[8*n-1]) begin
          mask = (32'h1 << (8*n)) - 32'h1;
          d = d | ~mask;
        end
      end
    end
  endfunction

  task automatic mon_one(input int id, input logic v, input logic [31:0] d, input logic [2:0] e);
    rsp_t f;
    logic due;
    due = 1'b0;
    f = '{0, 32'h0, 3'b000};
    if (id == 1) begin
      if (q1.size() > 0 && q1[0].due == cyc) begin due = 1'b1; f = q1.pop_front(); end
    end else begin
      if (q2.size() > 0 && q2[0].due == cyc) begin due = 1'b1; f = q2.pop_front(); end
    end
    tests++;
    if (v !== due) begin
      fails++;
      $display("FAIL rsp_valid dut%0d cyc=%0d got=%b want=%b", id, cyc, v, due);
    end else if (due) begin
      tests++;
      if (d !== f.data || e !== f.err) begin
        fails++;
        $display("FAIL rsp dut%0d cyc=%0d got data=%h err=%b want data=%h err=%b",
                 id, cyc, d, e, f.data, f.err);
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon_one(1, v1, d1, e1);
      mon_one(2, v2, d2, e2);
    end
  end

  task automatic drive(input logic we, input logic [1:0] sz, input logic sgn, input logic [31:0] a,
                       input logic [31:0] wd, input bit use_x, input logic [31:0] xd,
                       input logic [2:0] xe);
    logic [31:0] md;
    logic [2:0]  me;
    req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sgn; req_addr = a; req_wd = wd;
    $display("[TB] req cyc=%0d we=%0b size=%0d sgn=%0b addr=%h wd=%h ready=%0b",
             cyc, we, sz, sgn, a, wd, rdy1);
    if (rdy1 === 1'b1) begin
      model_req(we, sz, sgn, a, wd, md, me);
      if (use_x) begin md = xd; me = xe; end
      q1.push_back('{cyc + 1, md, me});
      q2.push_back('{cyc + 2, md, me});
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic idle();
    req_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q1.size() > 0 || q2.size() > 0) && n < 20) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (q1.size() > 0 || q2.size() > 0) begin
      fails++;
      $display("FAIL drain pending=%0d/%0d want 0/0", q1.size(), q2.size());
    end
  endtask

  // Holds a store request during the fill; it must never be accepted.
  task automatic init_wait();
    int cnt;
    bit bad;
    cnt = 0;
    bad = 1'b0;
    req_valid = 1'b1; req_we = 1'b1; req_size = SIZE_W; req_signed = 1'b0;
    req_addr = 32'h0; req_wd = 32'hFFFF_FFFF;
    while (rdy1 !== 1'b1 && cnt < 100) begin
      cnt++;
      if (done1 !== 1'b0 || done2 !== 1'b0 || rdy2 !== 1'b0) bad = 1'b1;
      @(negedge clk);
    end
    req_valid = 1'b0;
    for (int i = 0; i < NBYTES; i++) mdl[i] = 8'h00;
    tests++;
    if (cnt != 16) begin
      fails++;
      $display("FAIL init_len got=%0d want=16", cnt);
    end
    tests++;
    if ({rdy2, done1, done2} !== 3'b111 || bad) begin
      fails++;
      $display("FAIL init_flags got rdy2/done1/done2=%b early=%0b want 111/0", {rdy2, done1, done2}, bad);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0] sz;
    int r;

    vecs[0]  = '{1'b0, SIZE_W, 1'b0, 32'h00, 32'h0,         32'h0000_0000, 3'b000};
    vecs[1]  = '{1'b0, SIZE_W, 1'b0, 32'h0C, 32'h0,         32'h0000_0000, 3'b000};
    vecs[2]  = '{1'b1, SIZE_W, 1'b0, 32'h10, 32'h8765_4321, 32'h0000_0000, 3'b000};
    vecs[3]  = '{1'b0, SIZE_B, 1'b0, 32'h13, 32'h0,         32'h0000_0087, 3'b000};
    vecs[4]  = '{1'b0, SIZE_B, 1'b1, 32'h13, 32'h0,         32'hFFFF_FF87, 3'b000};
    vecs[5]  = '{1'b0, SIZE_H, 1'b1, 32'h12, 32'h0,         32'hFFFF_8765, 3'b000};
    vecs[6]  = '{1'b0, SIZE_H, 1'b0, 32'h10, 32'h0,         32'h0000_4321, 3'b000};
    vecs[7]  = '{1'b1, SIZE_B, 1'b0, 32'h11, 32'h1234_56AA, 32'h0000_0000, 3'b000};
    vecs[8]  = '{1'b0, SIZE_W, 1'b0, 32'h10, 32'h0,         32'h8765_AA21, 3'b000};
    vecs[9]  = '{1'b1, SIZE_H, 1'b0, 32'h11, 32'h0000_BEEF, 32'h0000_0000, 3'b001};
    vecs[10] = '{1'b0, SIZE_W, 1'b1, 32'h10, 32'h0,         32'h8765_AA21, 3'b000};
    vecs[11] = '{1'b0, SIZE_W, 1'b0, 32'h40, 32'h0,         32'h0000_0000, 3'b010};
    vecs[12] = '{1'b0, 2'd3,   1'b0, 32'h10, 32'h0,         32'h0000_0000, 3'b100};
    vecs[13] = '{1'b1, SIZE_W, 1'b0, 32'h41, 32'hDEAD_BEEF, 32'h0000_0000, 3'b011};
    vecs[14] = '{1'b0, 2'd3,   1'b0, 32'h43, 32'h0,         32'h0000_0000, 3'b110};
    vecs[15] = '{1'b0, SIZE_B, 1'b1, 32'h11, 32'h0,         32'hFFFF_FFAA, 3'b000};
    vecs[16] = '{1'b0, SIZE_H, 1'b0, 32'h13, 32'h0,         32'h0000_0000, 3'b001};
    vecs[17] = '{1'b1, SIZE_B, 1'b0, 32'h3F, 32'h0000_0080, 32'h0000_0000, 3'b000};
    vecs[18] = '{1'b0, SIZE_B, 1'b1, 32'h3F, 32'h0,         32'hFFFF_FF80, 3'b000};
    vecs[19] = '{1'b0, SIZE_H, 1'b1, 32'h3E, 32'h0,         32'hFFFF_8000, 3'b000};

    repeat (3) @(negedge clk);
    tests++;
    if ({rdy1, done1, v1, d1, e1} !== 38'h0) begin
      fails++;
      $display("FAIL reset_outs dut1 got=%h want=0", {rdy1, done1, v1, d1, e1});
    end
    tests++;
    if ({rdy2, done2, v2, d2, e2} !== 38'h0) begin
      fails++;
      $display("FAIL reset_outs dut2 got=%h want=0", {rdy2, done2, v2, d2, e2});
    end

    mon_en = 1'b1;
    rst_n = 1'b1;
    init_wait();

    for (int i = 0; i < 20; i++)
      drive(vecs[i].we, vecs[i].sz, vecs[i].sgn, vecs[i].addr, vecs[i].wd, 1'b1, vecs[i].xd, vecs[i].xe);
    drain();

    // Back-to-back word loads: responses must land on consecutive cycles in order.
    for (int k = 0; k < 4; k++)
      drive(1'b1, SIZE_W, 1'b0, 32'h20 + 32'(4*k), 32'h1111_0000 + 32'(k), 1'b1, 32'h0, 3'b000);
    for (int k = 0; k < 4; k++)
      drive(1'b0, SIZE_W, 1'b0, 32'h20 + 32'(4*k), 32'h0, 1'b1, 32'h1111_0000 + 32'(k), 3'b000);
    drain();

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 4) == 0) idle();
      else begin
        r = int'($urandom_range(0, 7));
        sz = (r < 7) ? 2'(r % 3) : 2'd3;
        drive(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
              32'($urandom_range(0, 32'h4F)), $urandom, 1'b0, 32'h0, 3'b000);
      end
    end
    drain();

    // Reset with two responses in flight on the latency-2 controller.
    drive(1'b1, SIZE_W, 1'b0, 32'h10, 32'hCAFE_F00D, 1'b0, 32'h0, 3'b000);
    drive(1'b0, SIZE_W, 1'b0, 32'h10, 32'h0, 1'b0, 32'h0, 3'b000);
    req_valid = 1'b1; req_we = 1'b0; req_size = SIZE_W; req_addr = 32'h14;
    @(posedge clk);
    #1;
    tests++;
    if (v2 !== 1'b1) begin
      fails++;
      $display("FAIL inflight dut2 valid got=%b want=1", v2);
    end
    rst_n = 1'b0;
    req_valid = 1'b0;
    q1.delete();
    q2.delete();
    #1;
    tests++;
    if ({v1, v2, rdy1, rdy2, done1, done2} !== 6'b0) begin
      fails++;
      $display("FAIL reset_drop got v1/v2/rdy1/rdy2/done1/done2=%b want 000000",
               {v1, v2, rdy1, rdy2, done1, done2});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    init_wait();
    drive(1'b0, SIZE_W, 1'b0, 32'h10, 32'h0, 1'b1, 32'h0000_0000, 3'b000);
    drive(1'b0, SIZE_W, 1'b0, 32'h00, 32'h0, 1'b1, 32'h0000_0000, 3'b000);
    drive(1'b0, SIZE_B, 1'b1, 32'h3F, 32'h0, 1'b1, 32'h0000_0000, 3'b000);
    drain();
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
